// File: rtl/ddr_wr_ctrl_if.sv
// Write-channel bundle between the write FIFO, the DDR arbiter and the MIG app interface.
// master = write controller, slave = FIFO/arbiter/MIG side.
interface ddr_wr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
);
  logic                      init_calib_complete;
  logic [15:0]               fifo_cnt;
  logic [DATA_WIDTH-1:0]     fifo_dout;
  logic                      fifo_rd_en;
  logic                      wr_req;
  logic                      wr_ack;
  logic                      wr_done;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [DATA_WIDTH-1:0]     app_wdf_data;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
  logic                      app_wdf_rdy;

  modport master (
    input  init_calib_complete, fifo_cnt, fifo_dout, wr_ack, app_rdy, app_wdf_rdy,
    output fifo_rd_en, wr_req, wr_done, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    output init_calib_complete, fifo_cnt, fifo_dout, wr_ack, app_rdy, app_wdf_rdy,
    input  fifo_rd_en, wr_req, wr_done, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );
endinterface

// File: rtl/ddr_wr_ctrl.sv
// DDR write-channel master: requests a burst once BURST_LEN words are buffered,
// then streams BURST_LEN write commands/data into the MIG app interface.
module ddr_wr_ctrl #(
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_STEP  = 8,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_END   = 32'h0080_0000
) (
  input  logic            ui_clk,
  input  logic            rst,
  ddr_wr_ctrl_if.master   bus
);

  localparam int unsigned           CNT_W      = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]      BEAT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      BEAT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ADDR_END - ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC   = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [15:0]           FIFO_THR   = 16'(BURST_LEN);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_REQ   = 4'b0010,
    S_WRITE = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr_req;
  logic [CNT_W-1:0]      r_beat;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic w_start;
  logic w_grant;
  logic w_fire;
  logic w_last;
  logic w_app_en;
  logic w_wr_done;

  // Command and data are only ever issued together, so one fire covers both.
  assign w_start = (r_state == S_IDLE) && bus.init_calib_complete && (bus.fifo_cnt >= FIFO_THR);
  assign w_grant = (r_state == S_REQ) && bus.wr_ack;
  assign w_fire  = (r_state == S_WRITE) && bus.app_rdy && bus.app_wdf_rdy;
  assign w_last  = w_fire && (r_beat == BEAT_LAST);

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (w_grant) w_next = S_WRITE;
      S_WRITE: if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_app_en  = 1'b0;
    w_wr_done = 1'b0;
    case (r_state)
      S_WRITE: w_app_en  = 1'b1;
      S_DONE:  w_wr_done = 1'b1;
      default: ;
    endcase
  end

  // Request flag, beat counter and address; address persists across bursts.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_wr_req <= 1'b0;
      r_beat   <= '0;
      r_addr   <= ADDR_FIRST;
    end else begin
      if (w_start)      r_wr_req <= 1'b1;
      else if (w_grant) r_wr_req <= 1'b0;

      if (w_grant)     r_beat <= '0;
      else if (w_fire) r_beat <= r_beat + BEAT_ONE;

      if (w_fire) r_addr <= (r_addr == ADDR_LAST) ? ADDR_FIRST : r_addr + ADDR_INC;
    end
  end

  assign bus.wr_req       = r_wr_req;
  assign bus.wr_done      = w_wr_done;
  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = 3'b000;
  assign bus.app_en       = w_app_en;
  assign bus.app_wdf_wren = w_app_en;
  assign bus.app_wdf_end  = w_app_en;
  assign bus.app_wdf_data = bus.fifo_dout;
  assign bus.app_wdf_mask = '0;
  assign bus.fifo_rd_en   = w_fire;

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Directed bench for ddr_wr_ctrl: request/grant handshake, streaming with stalls,
// address wrap (ADDR_END=0x210), asynchronous mid-burst reset and back-to-back bursts.
module tb_ddr_wr_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pop_idx;
  int   exp_idx;
  logic [AW-1:0] exp_addr;
  logic mon_fire;

  ddr_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr_wr_ctrl #(
    .BURST_LEN(64), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ADDR_STEP(8), .ADDR_BASE(0), .ADDR_END(32'h210)
  ) dut (
    .ui_clk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int i);
    return {32'hA5A5_0000 ^ 32'(i), 32'(i) * 32'd3, ~32'(i), 32'(i) + 32'h1234};
  endfunction

  // FIFO model: first-word-fall-through head advances on each pop.
  assign bus.fifo_dout = word(pop_idx);
  always @(posedge clk) if (bus.fifo_rd_en) pop_idx <= pop_idx + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard on every WRITE cycle: stable address/data while stalled, FIFO order on fire.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = '0;
    end else if (bus.app_en) begin
      mon_fire = bus.app_rdy && bus.app_wdf_rdy;
      check("mon_rd_en", bus.fifo_rd_en, mon_fire);
      check("mon_addr", bus.app_addr, exp_addr);
      check("mon_data", bus.app_wdf_data, word(exp_idx));
      check("mon_wren", bus.app_wdf_wren, 1);
      check("mon_end", bus.app_wdf_end, 1);
      if (mon_fire) begin
        exp_idx = exp_idx + 1;
        exp_addr = (exp_addr == AW'(32'h208)) ? '0 : exp_addr + AW'(8);
      end
    end else begin
      check("mon_idle_rd_en", bus.fifo_rd_en, 0);
    end
  end

  task automatic grant();
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    check("ack_req_drop", bus.wr_req, 0);
    check("ack_first_en", bus.app_en, 1);
  endtask

  // Runs WRITE until wr_done; returns the number of WRITE cycles observed.
  task automatic stream(input bit stall, output int en_cyc);
    logic [1:0] pat [4];
    logic seen;
    pat = '{2'b10, 2'b01, 2'b00, 2'b11};
    en_cyc = 0;
    seen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (stall) begin
        if (n < 4) {bus.app_rdy, bus.app_wdf_rdy} = pat[n];
        else       {bus.app_rdy, bus.app_wdf_rdy} = 2'($urandom_range(0, 3));
        if (n == 6) bus.wr_ack = 1'b1;
      end
      if (bus.app_en) en_cyc++;
      tick();
      bus.wr_ack = 1'b0;
      if (bus.wr_done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    check("done_seen", seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en;
    int p0;
    checks = 0; errors = 0; pop_idx = 0; exp_idx = 0; exp_addr = '0;
    rst = 1'b1;
    bus.init_calib_complete = 1'b0;
    bus.fifo_cnt = 16'd0;
    bus.wr_ack = 1'b0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    repeat (3) tick();
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_wr_done", bus.wr_done, 0);
    check("rst_app_en", bus.app_en, 0);
    check("rst_wren", bus.app_wdf_wren, 0);
    check("rst_fifo_rd", bus.fifo_rd_en, 0);
    check("rst_addr", bus.app_addr, 0);
    check("app_cmd", bus.app_cmd, 0);
    check("app_mask", bus.app_wdf_mask, 0);
    rst = 1'b0;
    tick();

    // Calibration gate, then first burst (FIFO order at 0x000..0x1F8)
    bus.fifo_cnt = 16'd200;
    repeat (5) tick();
    check("nocal_req", bus.wr_req, 0);
    bus.init_calib_complete = 1'b1;
    tick();
    check("cal_req", bus.wr_req, 1);
    repeat (4) tick();
    check("req_hold", bus.wr_req, 1);
    p0 = pop_idx;
    grant();
    stream(1'b0, en);
    check("a_en_cycles", en, 64);
    check("a_done", bus.wr_done, 1);
    bus.fifo_cnt = 16'd63;
    tick();
    check("a_done_pulse", bus.wr_done, 0);
    check("a_addr", bus.app_addr, 28'h200);
    check("a_pops", pop_idx - p0, 64);

    // Threshold and stray ack in IDLE
    repeat (3) tick();
    check("thr63_req", bus.wr_req, 0);
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    tick();
    check("idle_ack_req", bus.wr_req, 0);
    check("idle_ack_en", bus.app_en, 0);
    bus.fifo_cnt = 16'd64;
    tick();
    check("thr64_req", bus.wr_req, 1);

    // Stalled burst across the wrap (0x200, 0x208, 0x000 ...), stray ack in WRITE
    p0 = pop_idx;
    grant();
    stream(1'b1, en);
    check("b_stalled", en > 64, 1);
    check("b_done", bus.wr_done, 1);
    tick();
    check("b_pops", pop_idx - p0, 64);
    check("b_addr", bus.app_addr, 28'h1F0);
    check("b2b_gap", bus.wr_req, 0);
    tick();
    check("b2b_req", bus.wr_req, 1);

    // Asynchronous reset at beat 30
    grant();
    repeat (30) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_app_en", bus.app_en, 0);
    check("arst_wren", bus.app_wdf_wren, 0);
    check("arst_end", bus.app_wdf_end, 0);
    check("arst_rd_en", bus.fifo_rd_en, 0);
    check("arst_wr_req", bus.wr_req, 0);
    check("arst_wr_done", bus.wr_done, 0);
    check("arst_addr", bus.app_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("arst_no_done", bus.wr_done, 0);
    tick();
    check("arst_re_req", bus.wr_req, 1);
    check("arst_re_addr", bus.app_addr, 0);
    p0 = pop_idx;
    grant();
    stream(1'b0, en);
    check("d_en_cycles", en, 64);
    tick();
    check("d_addr", bus.app_addr, 28'h200);
    check("d_pops", pop_idx - p0, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_wr_ctrl.md
Name: ddr_wr_ctrl

Overview:
- Write-channel master between the write-data FIFO and the MIG user interface, upstream of the DDR read/write arbiter.
- When a full burst of data is buffered, it raises wr_req and waits for wr_ack. It then streams BURST_LEN write commands and data words into the MIG app interface, and finishes with a one-cycle wr_done that returns the arbiter to arbitration.

Parameters:
BURST_LEN, 64, beats (commands) per granted burst; >=2
ADDR_WIDTH, 28, app_addr width
DATA_WIDTH, 128, app_wdf_data width (one BL8 word per command)
ADDR_STEP, 8, app_addr increment per beat
ADDR_BASE, 0, first address after reset and after wrap
ADDR_END, 28'h0800000, exclusive upper bound; multiple of ADDR_STEP, > ADDR_BASE

Ports:
ui_clk  in  1  MIG user clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
init_calib_complete  in  1  MIG calibration done
fifo_cnt  in  16  words available in write FIFO (ui_clk domain)
fifo_dout  in  DATA_WIDTH  FIFO head word (first-word-fall-through)
fifo_rd_en  out  1  pop FIFO head
wr_req  out  1  burst request to arbiter
wr_ack  in  1  single-cycle grant from arbiter
wr_done  out  1  single-cycle burst-complete pulse to arbiter
app_addr  out  ADDR_WIDTH  command address
app_cmd  out  3  constant 3'b000 (write)
app_en  out  1  command valid
app_rdy  in  1  MIG command ready
app_wdf_data  out  DATA_WIDTH  write data
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last word of command; equals app_wdf_wren
app_wdf_mask  out  DATA_WIDTH/8  constant 0
app_wdf_rdy  in  1  MIG write-data ready

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - State IDLE.
  - wr_req, wr_done, app_en, app_wdf_wren, app_wdf_end, fifo_rd_en all 0.
  - app_addr=ADDR_BASE; beat counter 0.
- Reset mid-burst aborts the burst with no wr_done. Address restarts at ADDR_BASE.
- FSM, one-hot, 4 states:
  - IDLE: if init_calib_complete && fifo_cnt>=BURST_LEN, next=REQ and wr_req<=1 (registered). Otherwise stay.
  - REQ: wr_req held 1 until the cycle wr_ack=1 is sampled. That edge: wr_req<=0, next=WRITE, beat counter<=0. wr_ack in any other state is ignored.
  - WRITE: app_en=app_wdf_wren=app_wdf_end=1 (decoded from state).
    - fire = app_rdy && app_wdf_rdy. Command and data are issued only together. Stall holds app_addr and app_wdf_data stable.
    - fifo_rd_en = fire. app_wdf_data = fifo_dout (combinational pass-through).
    - On fire: beat counter +1; app_addr += ADDR_STEP, except if app_addr == ADDR_END-ADDR_STEP then app_addr <= ADDR_BASE (wrap).
    - On fire with beat counter == BURST_LEN-1: next=DONE.
  - DONE: wr_done=1 for exactly this cycle; next=IDLE.
- Minimum gap between wr_done and the next wr_req rising is 1 cycle (the IDLE evaluation cycle).
- Latency:
  - wr_req rises 1 cycle after the IDLE condition is met.
  - First app_en is 1 cycle after wr_ack is sampled.
  - Burst with no stalls: exactly BURST_LEN WRITE cycles, then 1 DONE cycle.
- fifo_cnt is sampled only in IDLE. The FIFO is not checked for empty during WRITE; the IDLE threshold guarantees BURST_LEN words are present.
- init_calib_complete dropping after IDLE does not abort the current request or burst.
- app_addr persists across bursts; consecutive bursts are address-contiguous modulo the wrap.
- Beat counter width is clog2(BURST_LEN)+1; the counter never exceeds BURST_LEN-1 when compared.

Test Plan:
1. Calib=0, fifo_cnt=200 -> wr_req stays 0. Raise calib -> wr_req=1 next cycle.
2. fifo_cnt=63 then 64 with BURST_LEN=64 -> no request at 63. At 64, wr_req=1; ack on cycle 5 -> wr_req=0, app_en high for exactly 64 cycles, then wr_done pulse 1 cycle, app_addr=0x200 afterwards.
3. Toggle app_rdy/app_wdf_rdy randomly (including app_rdy=1 with app_wdf_rdy=0) -> fifo_rd_en count == 64, and address/data are unchanged on every non-fire cycle. Scoreboard: data sequence matches FIFO order at addresses 0x000..0x1F8.
4. ADDR_END=0x210, start addr 0x000, two bursts of 64 -> second burst addresses go 0x200, 0x208, then 0x000, 0x008, ... with no gap.
5. Assert rst asynchronously at beat 30 -> all outputs 0 immediately (before the next edge), no wr_done, app_addr=ADDR_BASE. Next burst restarts cleanly.
6. wr_ack pulse while in IDLE or WRITE -> ignored, no state change. Back-to-back bursts with fifo_cnt≥128 -> wr_req re-asserts exactly 1 cycle after wr_done.
